// File: rtl/bla_serial_subtractor_pkg.sv
// Shared definitions for the serial borrow-lookahead subtractor: group width,
// FSM states and the group counter width helper.
package bla_serial_subtractor_pkg;

  localparam int GROUP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must be at least one bit even when there is a single group.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bla_serial_subtractor_group.sv
// Combinational 4-bit borrow-lookahead group: per-bit difference plus group
// borrow generate (D), propagate (Q) and borrow-out.
module bla_group
  import bla_serial_subtractor_pkg::*;
(
  input  logic [GROUP_W-1:0] a_i,
  input  logic [GROUP_W-1:0] b_i,
  input  logic               bin_i,
  output logic [GROUP_W-1:0] diff_o,
  output logic               d_o,
  output logic               q_o,
  output logic               bout_o
);

  logic [GROUP_W-1:0] d;
  logic [GROUP_W-1:0] q;
  logic [GROUP_W:0]   brw;

  assign d = ~a_i & b_i;
  assign q = ~(a_i ^ b_i);

  // Internal borrows are expanded in lookahead form rather than rippled.
  assign brw[0] = bin_i;
  assign brw[1] = d[0] | (q[0] & bin_i);
  assign brw[2] = d[1] | (q[1] & d[0]) | (q[1] & q[0] & bin_i);
  assign brw[3] = d[2] | (q[2] & d[1]) | (q[2] & q[1] & d[0])
                | (q[2] & q[1] & q[0] & bin_i);

  assign d_o    = d[3] | (q[3] & (d[2] | (q[2] & (d[1] | (q[1] & d[0])))));
  assign q_o    = &q;
  assign brw[4] = d_o | (q_o & bin_i);
  assign bout_o = brw[4];

  assign diff_o = a_i ^ b_i ^ brw[GROUP_W-1:0];

endmodule

// File: rtl/bla_serial_subtractor.sv
// Serial subtractor: a - b - bin computed one 4-bit group per clock through a
// single time-multiplexed borrow-lookahead group, with valid/ready on both sides.
//
// state | meaning
// IDLE  | ready for operands, in_ready_o high
// RUN   | processing group k_q, one group per cycle
// DONE  | result valid, held until out_ready_i
module bla_serial_subtractor
  import bla_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o,
  output logic             ovf_o
);

  localparam int N  = WIDTH / GROUP_W;
  localparam int KW = cnt_width(N);
  localparam int IW = KW + 2;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [IW-1:0]      base;
  logic [GROUP_W-1:0] grp_a, grp_b, grp_diff;
  logic               grp_d, grp_q, grp_bout;

  assign base  = {k_q, 2'b00};
  assign grp_a = a_q[base +: GROUP_W];
  assign grp_b = b_q[base +: GROUP_W];

  bla_group u_group (
    .a_i    (grp_a),
    .b_i    (grp_b),
    .bin_i  (borrow_q),
    .diff_o (grp_diff),
    .d_o    (grp_d),
    .q_o    (grp_q),
    .bout_o (grp_bout)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          a_d      = a_i;
          b_d      = b_i;
          borrow_d = bin_i;
          k_d      = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        diff_d[base +: GROUP_W] = grp_diff;
        borrow_d = grp_d | (grp_q & borrow_q);
        if (k_q == KW'(N - 1)) begin
          bout_d  = grp_bout;
          ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (grp_diff[GROUP_W-1] ^ a_q[WIDTH-1]);
          k_d     = '0;
          state_d = ST_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = (state_q == ST_DONE);
  assign diff_o      = diff_q;
  assign bout_o      = bout_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_bla_serial_subtractor.sv
// Self-checking bench: directed and random subtractions against an integer
// reference model, with latency, back-pressure and mid-operation reset checks.
module tb_bla_serial_subtractor;
  parameter int WIDTH = 16;
  localparam int N = WIDTH / 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i, b_i;
  logic             bin_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] diff_o;
  logic             bout_o;
  logic             ovf_o;

  int n_checks = 0;
  int n_errors = 0;

  bla_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .bin_i       (bin_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .diff_o      (diff_o),
    .bout_o      (bout_o),
    .ovf_o       (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned and signed integer subtraction, range-checked.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic bin, output logic [WIDTH-1:0] d,
                                output logic bo, output logic ov);
    longint ur, sr, sa, sb, smax, smin;
    ur   = longint'({1'b0, a}) - longint'({1'b0, b}) - longint'(bin);
    d    = ur[WIDTH-1:0];
    bo   = (ur < 0);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sr   = sa - sb - longint'(bin);
    smax = (64'sd1 <<< (WIDTH - 1)) - 1;
    smin = -(64'sd1 <<< (WIDTH - 1));
    ov   = (sr > smax) || (sr < smin);
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"},  64'(in_ready_o),  64'd1);
    check({tag, " out_valid"}, 64'(out_valid_o), 64'd0);
    check({tag, " diff"},      64'(diff_o),      64'd0);
    check({tag, " bout"},      64'(bout_o),      64'd0);
    check({tag, " ovf"},       64'(ovf_o),       64'd0);
  endtask

  // One full transaction; optional junk in_valid during RUN and a hold of
  // out_ready low for 'hold' cycles once the result appears.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bin, input int hold, input bit junk);
    logic [WIDTH-1:0] ed, sd;
    logic eb, eo, sb, so;
    int lat;
    bit ready_bad, hold_bad;
    model(a, b, bin, ed, eb, eo);
    a_i = a; b_i = b; bin_i = bin; in_valid_i = 1'b1; out_ready_i = 1'b0;
    step();
    if (junk) begin
      a_i = ~a; b_i = a; bin_i = ~bin;
    end else begin
      in_valid_i = 1'b0;
      a_i = WIDTH'($urandom); b_i = WIDTH'($urandom);
    end
    lat = 0;
    ready_bad = 1'b0;
    while (!out_valid_o && lat < N + 5) begin
      if (in_ready_o) ready_bad = 1'b1;
      step();
      lat++;
    end
    in_valid_i = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(N));
    check({tag, " diff"}, 64'(diff_o), 64'(ed));
    check({tag, " bout"}, 64'(bout_o), 64'(eb));
    check({tag, " ovf"},  64'(ovf_o),  64'(eo));
    sd = diff_o; sb = bout_o; so = ovf_o;
    hold_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (!out_valid_o || in_ready_o || diff_o !== sd || bout_o !== sb || ovf_o !== so)
        hold_bad = 1'b1;
    end
    if (in_ready_o) ready_bad = 1'b1;
    check({tag, " in_ready low while busy"}, 64'(ready_bad), 64'd0);
    if (hold > 0) check({tag, " held under back-pressure"}, 64'(hold_bad), 64'd0);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    check({tag, " out_valid after consume"}, 64'(out_valid_o), 64'd0);
    check({tag, " in_ready after consume"},  64'(in_ready_o),  64'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    a_i = '0; b_i = '0; bin_i = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) step();
    rst_i = 1'b0;
    step();
    check_reset_outputs("post-reset");

    run_op("d1", WIDTH'(32'h1234), WIDTH'(32'h0234), 1'b0, 0, 1'b0);
    run_op("d2", WIDTH'(32'h0000), WIDTH'(32'h0001), 1'b0, 0, 1'b0);
    run_op("d3", WIDTH'(32'h8000), WIDTH'(32'h0001), 1'b0, 0, 1'b0);
    run_op("d4", WIDTH'(32'h7FFF), WIDTH'(32'hFFFF), 1'b0, 0, 1'b0);
    run_op("d5", WIDTH'(32'h0010), WIDTH'(32'h000F), 1'b1, 0, 1'b1);
    run_op("msb", {1'b1, {(WIDTH-1){1'b0}}}, {1'b0, {(WIDTH-1){1'b1}}}, 1'b1, 0, 1'b0);
    run_op("bp", WIDTH'(32'hBEEF), WIDTH'(32'h1357), 1'b1, 10, 1'b0);

    // Reset during the second RUN cycle aborts the operation.
    a_i = WIDTH'(32'hA5A5); b_i = WIDTH'(32'h0F0F); bin_i = 1'b0; in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    step();
    rst_i = 1'b1;
    #1;
    check_reset_outputs("mid-run reset");
    step();
    rst_i = 1'b0;
    step();
    check_reset_outputs("after abort");
    run_op("post-abort", WIDTH'(32'hA5A5), WIDTH'(32'h0F0F), 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (i % 8 == 0) rb = ra;
      run_op($sformatf("rnd%0d", i), ra, rb, 1'($urandom), int'($urandom_range(0, 3)),
             1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
